// File: rtl/song_seq_axil_responder.sv
// rtl/song_seq_axil_responder.sv - AXI4-Lite register slave driving a tempo/length note sequencer (optional STATUS reg: SONG_SEQ_STATUS_REG_EN)
module song_seq_axil_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic [2:0]                        AWPROT,
    input  logic                              AWVALID,
    output logic                              AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                              WVALID,
    output logic                              WREADY,
    output logic [1:0]                        BRESP,
    output logic                              BVALID,
    input  logic                              BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
    input  logic [2:0]                        ARPROT,
    input  logic                              ARVALID,
    output logic                              ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                        RRESP,
    output logic                              RVALID,
    input  logic                              RREADY,
    output logic [7:0]                        note_idx,
    output logic                              note_tick,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     volume,
    output logic                              seq_done
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } seq_state_t;

    seq_state_t    state;
    logic          awready_q;
    logic          arready_q;
    logic          bvalid_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] regs     [4];
    logic [DW-1:0] regs_nxt [4];
    logic [DW-1:0] rd_mux;
    logic [31:0]   tick_cnt;

    logic wr_fire;
    logic rd_fire;
    logic play;
    logic loop_en;
    logic [DW-1:0] tempo;
    logic [7:0]    song_len;
    logic advance;
    logic last_note;
    logic unused_bits;

    assign wr_fire  = awready_q & AWVALID & WVALID;
    assign rd_fire  = arready_q & ARVALID;

    assign AWREADY  = awready_q;
    assign WREADY   = awready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = 2'b00;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = 2'b00;

    assign play     = regs[0][0];
    assign loop_en  = regs[0][1];
    assign tempo    = regs[1];
    assign song_len = regs[2][7:0];
    assign volume   = regs[3];

    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0],
                           regs[0][DW-1:2], regs[2][DW-1:8]};

    // Post-write register image; reads use it so a same-edge write is visible.
    always_comb begin
        for (int i = 0; i < 4; i++) regs_nxt[i] = regs[i];
        if (wr_fire && !AWADDR[4]) begin
            for (int b = 0; b < SW; b++) begin
                if (WSTRB[b]) regs_nxt[AWADDR[3:2]][8*b +: 8] = WDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (ARADDR[4:2])
            3'd0: rd_mux = regs_nxt[0];
            3'd1: rd_mux = regs_nxt[1];
            3'd2: rd_mux = regs_nxt[2];
            3'd3: rd_mux = regs_nxt[3];
`ifdef SONG_SEQ_STATUS_REG_EN
            3'd4: begin
                rd_mux[7:0] = note_idx;
                rd_mux[8]   = (state == S_PLAY);
                rd_mux[9]   = seq_done;
            end
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            awready_q <= !awready_q && AWVALID && WVALID && !bvalid_q;
            for (int i = 0; i < 4; i++) regs[i] <= regs_nxt[i];
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= !arready_q && ARVALID && !rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // >= rather than == so a TEMPO shrunk mid-note still advances promptly.
    assign advance   = (tempo <= 32'd1) || (tick_cnt >= tempo - 32'd1);
    assign last_note = ({1'b0, note_idx} + 9'd1) >= {1'b0, song_len};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            note_idx  <= '0;
            note_tick <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            note_tick <= 1'b0;
            if (!play) begin
                state    <= S_IDLE;
                tick_cnt <= '0;
                note_idx <= '0;
                seq_done <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (song_len != 8'd0) begin
                            state    <= S_PLAY;
                            tick_cnt <= '0;
                            note_idx <= '0;
                        end
                    end
                    S_PLAY: begin
                        if (advance) begin
                            note_tick <= 1'b1;
                            tick_cnt  <= '0;
                            if (!last_note) begin
                                note_idx <= note_idx + 8'd1;
                            end else if (loop_en) begin
                                note_idx <= '0;
                            end else begin
                                state    <= S_DONE;
                                seq_done <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 32'd1;
                        end
                    end
                    S_DONE: begin
                        seq_done <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
